// File: rtl/asram_pkg.sv
// Shared types and constants for the asynchronous-SRAM controller.
// Lane helpers turn the data-bus width into the byte-lane count and byte-address shift.
package asram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;

    localparam int WAIT_CNT_W = 4;

    function automatic int lane_count(input int dwidth);
        return dwidth / 8;
    endfunction

    function automatic int lane_lsb(input int dwidth);
        return dwidth / 8 - 1;
    endfunction

endpackage

// File: rtl/asram_wait_cnt.sv
// Loadable wait-state down-counter; it holds at zero and flags it.
module asram_wait_cnt
    import asram_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  dec,
    input  logic [WAIT_CNT_W-1:0] load_val,
    output logic                  zero
);

    logic [WAIT_CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/asram_ws_intf.sv
// ASRAM controller joining the core's instruction and data ports onto one chip.
// Data requests win arbitration; an 8-bit bus fetches each instruction as two byte reads.
module asram_ws_intf
    import asram_pkg::*;
#(
    parameter int RAM_AWIDTH = 17,
    parameter int RAM_DWIDTH = 16,
    parameter int RD_WAIT    = 1,
    parameter int WR_WAIT    = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  instr_sel,
    input  logic [RAM_AWIDTH+RAM_DWIDTH/8-2:0]    cpu_iaddr,
    output logic [15:0]                           instr,
    output logic                                  WAIT_INSTR,
    input  logic [RAM_AWIDTH+RAM_DWIDTH/8-2:0]    cpu_daddr,
    input  logic                                  dread,
    input  logic                                  dwrite,
    input  logic [7:0]                            ddata_o,
    output logic [7:0]                            ddata_i,
    output logic                                  WAIT_DATA,
    output logic [RAM_AWIDTH-1:0]                 ram_addr,
    output logic                                  ram_cen,
    output logic                                  ram_oen,
    output logic                                  ram_wen,
    output logic [RAM_DWIDTH/8-1:0]               ram_wstrbn,
    inout  wire  [RAM_DWIDTH-1:0]                 ram_data
);

    localparam int LANES = lane_count(RAM_DWIDTH);
    localparam int LB    = lane_lsb(RAM_DWIDTH);
    localparam bit SPLIT_FETCH = (LANES == 1);
    localparam logic [WAIT_CNT_W-1:0] RD_LOAD = WAIT_CNT_W'(RD_WAIT);
    localparam logic [WAIT_CNT_W-1:0] WR_LOAD = WAIT_CNT_W'(WR_WAIT);

    state_t state, next_state;

    logic                  cnt_load, cnt_dec, cnt_zero;
    logic [WAIT_CNT_W-1:0] cnt_val;
    logic                  start_data, start_write, start_fetch, next_half, finish;

    logic                  ifetch, half, is_write, lane_q, idone, ddone;
    logic [RAM_AWIDTH-1:0] addr_q, fetch_addr;
    logic [7:0]            wdata_q, rd_byte;
    logic [15:0]           fetch_word;
    logic [LANES-1:0]      wr_mask;
    logic                  bus_drive;
    logic                  unused_iaddr;

    asram_wait_cnt u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // NOTE: state is updated with non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        next_state  = state;
        cnt_load    = 1'b0;
        cnt_val     = '0;
        cnt_dec     = 1'b0;
        start_data  = 1'b0;
        start_write = 1'b0;
        start_fetch = 1'b0;
        next_half   = 1'b0;
        finish      = 1'b0;
        ram_cen     = 1'b1;
        ram_oen     = 1'b1;
        ram_wen     = 1'b1;
        ram_wstrbn  = '1;
        case (state)
            IDLE: begin
                if (dwrite) begin
                    next_state  = WR;
                    cnt_load    = 1'b1;
                    cnt_val     = WR_LOAD;
                    start_data  = 1'b1;
                    start_write = 1'b1;
                end else if (dread) begin
                    next_state = RD;
                    cnt_load   = 1'b1;
                    cnt_val    = RD_LOAD;
                    start_data = 1'b1;
                end else if (instr_sel) begin
                    next_state  = RD;
                    cnt_load    = 1'b1;
                    cnt_val     = RD_LOAD;
                    start_fetch = 1'b1;
                end
            end
            RD: begin
                ram_cen    = 1'b0;
                ram_oen    = 1'b0;
                ram_wstrbn = '0;
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (SPLIT_FETCH && ifetch && !half) begin
                    next_half = 1'b1;
                    cnt_load  = 1'b1;
                    cnt_val   = RD_LOAD;
                end else begin
                    finish     = 1'b1;
                    next_state = DONE;
                end
            end
            WR: begin
                ram_cen    = 1'b0;
                ram_wen    = 1'b0;
                ram_wstrbn = wr_mask;
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    finish     = 1'b1;
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Bus-width specific lane steering and fetch addressing.
    generate
        if (LANES == 2) begin : g_bus16
            assign rd_byte      = lane_q ? ram_data[15:8] : ram_data[7:0];
            assign fetch_word   = ram_data;
            assign wr_mask      = {~lane_q, lane_q};
            assign fetch_addr   = cpu_iaddr[RAM_AWIDTH-1:0];
            assign unused_iaddr = cpu_iaddr[RAM_AWIDTH];
        end else begin : g_bus8
            assign rd_byte      = ram_data;
            assign fetch_word   = {ram_data, instr[7:0]};
            assign wr_mask      = '0;
            assign fetch_addr   = {cpu_iaddr[RAM_AWIDTH-2:0], 1'b0};
            assign unused_iaddr = cpu_iaddr[RAM_AWIDTH-1] ^ lane_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            instr    <= '0;
            ddata_i  <= '0;
            idone    <= 1'b0;
            ddone    <= 1'b0;
            ifetch   <= 1'b0;
            half     <= 1'b0;
            is_write <= 1'b0;
            lane_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            idone <= finish && ifetch;
            ddone <= finish && !ifetch;
            if (start_data) begin
                addr_q   <= cpu_daddr[RAM_AWIDTH+LB-1:LB];
                lane_q   <= cpu_daddr[0];
                wdata_q  <= ddata_o;
                is_write <= start_write;
                ifetch   <= 1'b0;
                half     <= 1'b0;
            end else if (start_fetch) begin
                addr_q   <= fetch_addr;
                is_write <= 1'b0;
                ifetch   <= 1'b1;
                half     <= 1'b0;
            end
            if (next_half) begin
                half       <= 1'b1;
                addr_q[0]  <= 1'b1;
                instr[7:0] <= rd_byte;
            end
            if (finish && !is_write) begin
                if (ifetch) begin
                    instr <= fetch_word;
                end else begin
                    ddata_i <= rd_byte;
                end
            end
        end
    end

    // Write data stays on the bus through DONE as a hold cycle after wen rises.
    assign bus_drive  = (state == WR) || ((state == DONE) && is_write);
    assign ram_data   = bus_drive ? {LANES{wdata_q}} : {RAM_DWIDTH{1'bz}};
    assign ram_addr   = addr_q;
    assign WAIT_INSTR = !(instr_sel && idone);
    assign WAIT_DATA  = (dread || dwrite) && !ddone;

endmodule
